// File: rtl/main_core_serial_cmd.sv
// rtl/main_core_serial_cmd.sv - serial command front end and outer/mem word router
module main_core_serial_cmd #(
  parameter int WHICH_W = 3,
  parameter int SER_W   = 13,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WHICH_W+SER_W-1:0] cmd,
  input  logic                     cmd_hasAny,
  output logic                     cmd_consume,
  input  logic [DATA_W-1:0]        in,
  input  logic                     in_isReady,
  output logic                     in_canReceive,
  output logic [DATA_W-1:0]        out,
  output logic                     out_isReady,
  input  logic                     out_canReceive
);

  localparam logic [WHICH_W-1:0] CMD_NOP    = WHICH_W'(0);
  localparam logic [WHICH_W-1:0] CMD_ROUTE  = WHICH_W'(1);
  localparam logic [WHICH_W-1:0] CMD_XFER   = WHICH_W'(2);
  localparam logic [WHICH_W-1:0] CMD_MEMPTR = WHICH_W'(3);

  localparam logic [3:0] EP_OUTER = 4'b1000;
  localparam logic [3:0] EP_MEM   = 4'b0010;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              route_valid;
  logic              src_outer;
  logic              dst_outer;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] wrptr;
  logic [ADDR_W-1:0] rdptr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  logic [WHICH_W-1:0] which;
  logic [SER_W-1:0]   payload;
  logic [3:0]         route_src;
  logic [3:0]         route_dst;
  logic               route_ok;
  logic               idle;
  logic               busy;
  logic               out_free;
  logic               dst_ready;
  logic               src_ready;
  logic               move;
  logic [DATA_W-1:0]  word;
  logic [2:0]         unused_payload;

  assign which          = cmd[WHICH_W+SER_W-1:SER_W];
  assign payload        = cmd[SER_W-1:0];
  assign route_src      = payload[3:0];
  assign route_dst      = payload[7:4];
  assign unused_payload = payload[SER_W-1:10];

  always_comb begin
    route_ok = ((route_src == EP_OUTER) || (route_src == EP_MEM)) &&
               ((route_dst == EP_OUTER) || (route_dst == EP_MEM));
    idle      = (remaining == '0) && !out_valid;
    busy      = (remaining != '0);
    // A draining out register can be refilled on the same edge.
    out_free  = !out_valid || out_canReceive;
    dst_ready = dst_outer ? out_free : 1'b1;
    src_ready = src_outer ? in_isReady : 1'b1;
    move      = !rst && busy && dst_ready && src_ready;
    word      = src_outer ? in : mem[rdptr];
    cmd_consume   = !rst && cmd_hasAny && idle;
    in_canReceive = !rst && busy && src_outer && dst_ready;
  end

  assign out         = out_data;
  assign out_isReady = out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      route_valid <= 1'b0;
      src_outer   <= 1'b0;
      dst_outer   <= 1'b0;
      remaining   <= '0;
      wrptr       <= '0;
      rdptr       <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
    end else begin
      if (out_valid && out_canReceive) begin
        out_valid <= 1'b0;
      end
      if (move) begin
        remaining <= remaining - CNT_W'(1);
        if (dst_outer) begin
          out_data  <= word;
          out_valid <= 1'b1;
        end else begin
          wrptr <= wrptr + ADDR_W'(1);
        end
        if (!src_outer) begin
          rdptr <= rdptr + ADDR_W'(1);
        end
      end
      // Commands are only consumed while idle, so they never race a move.
      if (cmd_consume) begin
        case (which)
          CMD_NOP: ;
          CMD_ROUTE: begin
            route_valid <= route_ok;
            src_outer   <= (route_src == EP_OUTER);
            dst_outer   <= (route_dst == EP_OUTER);
          end
          CMD_XFER: begin
            if (route_valid) begin
              remaining <= payload[CNT_W-1:0];
            end
          end
          CMD_MEMPTR: begin
            if (payload[9]) begin
              rdptr <= payload[ADDR_W-1:0];
            end else begin
              wrptr <= payload[ADDR_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (move && !dst_outer) begin
      mem[wrptr] <= word;
    end
  end

endmodule

// File: tb/tb_main_core_serial_cmd.sv
// tb/tb_main_core_serial_cmd.sv - scoreboard bench for main_core_serial_cmd
module tb_main_core_serial_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        cmd_hasAny;
  logic        cmd_consume;
  logic [63:0] in_word;
  logic        in_isReady;
  logic        in_canReceive;
  logic [63:0] out_word;
  logic        out_isReady;
  logic        out_canReceive;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];

  main_core_serial_cmd dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd),
    .cmd_hasAny     (cmd_hasAny),
    .cmd_consume    (cmd_consume),
    .in             (in_word),
    .in_isReady     (in_isReady),
    .in_canReceive  (in_canReceive),
    .out            (out_word),
    .out_isReady    (out_isReady),
    .out_canReceive (out_canReceive)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so a negedge sample predicts the next edge's handshake.
  always @(negedge clk) begin
    logic [63:0] exp_w;
    if (!rst && out_isReady && out_canReceive) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %h, expected no word", out_word);
      end else begin
        exp_w = exp_q.pop_front();
        if (out_word !== exp_w) begin
          bad++;
          $display("FAIL out_data: got %h, expected %h", out_word, exp_w);
        end
      end
    end
  end

  task automatic do_cmd(input logic [15:0] c);
    bit got = 0;
    cmd = c;
    cmd_hasAny = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (cmd_consume) got = 1;
      @(posedge clk); #1;
    end
    cmd_hasAny = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL cmd_timeout: cmd %h not consumed, expected consume", c);
    end
  endtask

  task automatic send_word(input logic [63:0] w);
    bit got = 0;
    in_word = w;
    in_isReady = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_canReceive) got = 1;
      @(posedge clk); #1;
    end
    in_isReady = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_timeout: word %h not accepted, expected accept", w);
    end
  endtask

  task automatic wait_idle(input string name);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (!out_isReady && exp_q.size() == 0) got = 1;
      @(posedge clk); #1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_drain: %0d words pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    total++;
    if (out_isReady !== 1'b0) begin
      bad++;
      $display("FAIL %s_out_isReady: got %b, expected 0", name, out_isReady);
    end
    total++;
    if (in_canReceive !== 1'b0) begin
      bad++;
      $display("FAIL %s_in_canReceive: got %b, expected 0", name, in_canReceive);
    end
    total++;
    if (cmd_consume !== 1'b0) begin
      bad++;
      $display("FAIL %s_cmd_consume: got %b, expected 0", name, cmd_consume);
    end
    total++;
    if (out_word !== 64'h0) begin
      bad++;
      $display("FAIL %s_out: got %h, expected 0", name, out_word);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    rst = 1'b0;
    check_idle_outputs("reset_idle");
  endtask

  task automatic test_loopback();
    logic [63:0] words [3];
    words[0] = 64'h1111111111111111;
    words[1] = 64'h2222222222222222;
    words[2] = 64'h3333333333333333;
    out_canReceive = 1'b1;
    do_cmd(16'h2088);
    do_cmd(16'h4003);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(words[i]);
      send_word(words[i]);
    end
    in_word = 64'h4444444444444444;
    in_isReady = 1'b1;
    @(negedge clk);
    total++;
    if (in_canReceive !== 1'b0) begin
      bad++;
      $display("FAIL loopback_fourth: in_canReceive %b, expected 0", in_canReceive);
    end
    @(posedge clk); #1;
    in_isReady = 1'b0;
    wait_idle("loopback");
  endtask

  task automatic store_readback(input logic [7:0] addr, input logic [63:0] w0,
                                input logic [63:0] w1);
    out_canReceive = 1'b1;
    do_cmd({8'h60, addr});
    do_cmd(16'h2028);
    do_cmd(16'h4002);
    send_word(w0);
    send_word(w1);
    wait_idle("store");
    do_cmd({8'h62, addr});
    do_cmd(16'h2082);
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    do_cmd(16'h4002);
    wait_idle("readback");
  endtask

  task automatic test_store_readback();
    store_readback(8'h05, 64'hDEADBEEF00000001, 64'hDEADBEEF00000002);
    store_readback(8'hFF, 64'hCAFEF00D000000AA, 64'hCAFEF00D000000BB);
  endtask

  task automatic test_backpressure();
    logic [63:0] w1 = 64'hA1A1A1A1A1A1A1A1;
    logic [63:0] w2 = 64'hB2B2B2B2B2B2B2B2;
    logic [63:0] w3 = 64'hC3C3C3C3C3C3C3C3;
    out_canReceive = 1'b0;
    do_cmd(16'h2088);
    do_cmd(16'h4003);
    exp_q.push_back(w1);
    send_word(w1);
    in_word = w2;
    in_isReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_isReady !== 1'b1 || out_word !== w1) begin
        bad++;
        $display("FAIL bp_hold: out %h valid %b, expected %h valid 1", out_word, out_isReady, w1);
      end
      total++;
      if (in_canReceive !== 1'b0) begin
        bad++;
        $display("FAIL bp_in_canReceive: got %b, expected 0", in_canReceive);
      end
      @(posedge clk); #1;
    end
    out_canReceive = 1'b1;
    exp_q.push_back(w2);
    send_word(w2);
    exp_q.push_back(w3);
    send_word(w3);
    wait_idle("backpressure");
  endtask

  task automatic test_keccak();
    out_canReceive = 1'b1;
    do_cmd(16'h2044);
    do_cmd(16'h4004);
    in_word = 64'h5555555555555555;
    in_isReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_canReceive !== 1'b0 || out_isReady !== 1'b0) begin
        bad++;
        $display("FAIL keccak_quiet: in_canReceive %b out_isReady %b, expected 0 0",
                 in_canReceive, out_isReady);
      end
      @(posedge clk); #1;
    end
    in_isReady = 1'b0;
    cmd = 16'h0000;
    cmd_hasAny = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_consume !== 1'b1) begin
      bad++;
      $display("FAIL keccak_nop: cmd_consume %b, expected 1", cmd_consume);
    end
    @(posedge clk); #1;
    cmd_hasAny = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_canReceive = 1'b0;
    do_cmd(16'h2088);
    do_cmd(16'h4003);
    send_word(64'h7777777777777777);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("reset_mid");
    out_canReceive = 1'b1;
    do_cmd(16'h4003);
    in_word = 64'h8888888888888888;
    in_isReady = 1'b1;
    cmd = 16'h0000;
    cmd_hasAny = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_consume !== 1'b1) begin
      bad++;
      $display("FAIL noroute_done: cmd_consume %b, expected 1", cmd_consume);
    end
    total++;
    if (in_canReceive !== 1'b0 || out_isReady !== 1'b0) begin
      bad++;
      $display("FAIL noroute_quiet: in_canReceive %b out_isReady %b, expected 0 0",
               in_canReceive, out_isReady);
    end
    @(posedge clk); #1;
    cmd_hasAny = 1'b0;
    in_isReady = 1'b0;
    wait_idle("reset_mid");
  endtask

  initial begin
    rst = 1'b1;
    cmd = '0;
    cmd_hasAny = 1'b0;
    in_word = '0;
    in_isReady = 1'b0;
    out_canReceive = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_loopback();
    test_store_readback();
    test_backpressure();
    test_keccak();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_core_serial_cmd.md
# main_core_serial_cmd

Serial-command front end and data-routing engine for the FrodoKEM main core. It accepts one packed command word at a time and dispatches it: configuring a source→destination route, moving a counted number of 64-bit words along that route, or setting memory pointers. The external 64-bit streaming port ("outer") and an internal word memory are the endpoints. The Keccak and seedA endpoints are reserved selectors with no datapath inside this block.

## Interface
- `WHICH_W`, 3: command selector width (`MainCoreCMD_which_SIZE`).
- `SER_W`, 13: command payload width (`MainCoreSerialCMD_SIZE`).
- `DATA_W`, 64: word width.
- `ADDR_W`, 8: memory address width (256 words).
- `CNT_W`, 9: transfer count width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd` in WHICH_W+SER_W: command. `cmd[15:13]` is `which`; `cmd[12:0]` is payload.
- `cmd_hasAny` in 1: `cmd` is valid.
- `cmd_consume` out 1: command accepted this cycle (combinational).
- `in` in 64: inbound word.
- `in_isReady` in 1: `in` is valid.
- `in_canReceive` out 1: block accepts `in` this cycle.
- `out` out 64: outbound word (registered).
- `out_isReady` out 1: `out` is valid.
- `out_canReceive` in 1: consumer accepts `out`.

## Operation
- Endpoint one-hot code, 4 bits: bit3 outer, bit2 keccak, bit1 mem, bit0 seedA.
- `which` = 0: NOP.
- `which` = 1: ROUTE. `payload[7:4]` is dst and `payload[3:0]` is src.
  - The route is valid only if src and dst are each exactly one of outer or mem.
  - Any other code stores "no route".
- `which` = 2: XFER. `payload[8:0]` is N.
  - Moves N words src→dst in order, at most one word per cycle.
  - With no valid route, or N = 0, it completes immediately and moves no data.
- `which` = 3: MEMPTR. `payload[9]` selects the pointer: 0 = write pointer, 1 = read pointer. `payload[7:0]` is the address.
- `which` = 4–7: consumed and ignored.
- Engine is idle when the remaining count is 0 and the `out` register is empty.
- `cmd_consume` = `cmd_hasAny` & idle. The command is executed at that rising edge. ROUTE, MEMPTR and NOP take effect in that one cycle.
- Source outer: a word moves when `in_isReady` & `in_canReceive`.
- Source mem: the word comes from `mem[rdptr]` via asynchronous read; `rdptr` increments per word moved.
- Destination mem: writes `mem[wrptr]`; `wrptr` increments per word moved.
- Destination outer: the word loads into the `out` register (one entry). It leaves on `out_isReady` & `out_canReceive`.
- The `out` register is "free" when empty, or when it is being drained in the same cycle.
- A word moves only if the destination can take it: mem always can; outer only when the `out` register is free.
- `in_canReceive` = busy & src==outer & remaining>0 & destination can take a word.
- Mem→mem copies one word per cycle. Outer→outer is a registered loopback.
- Pointers wrap modulo 256. Memory contents are not reset.
- Reset values:
  - `cmd_consume` = 0, `in_canReceive` = 0, `out_isReady` = 0, `out` = 0.
  - Route = none, remaining count = 0, both pointers = 0.
- Reset mid-transfer aborts the transfer and discards any word in the `out` register.

## Timing
- Command acceptance: zero-cycle combinational `cmd_consume` when idle. While busy, `cmd_consume` stays 0 and the command is held off.
- Outer→outer: a word accepted at edge k is presented on `out` with `out_isReady` = 1 after edge k.
- Mem→outer: the first word is on `out` one cycle after the XFER edge.
- `out` stays stable while `out_isReady` = 1 and `out_canReceive` = 0.
- Full throughput is one word per cycle when the consumer is always ready.
- XFER completes on the edge where the last word leaves the `out` register (outer destination) or is written (mem destination). The next command can be consumed in the following cycle.

## Test plan
- Reset then idle → `out_isReady` = 0 and `in_canReceive` = 0. With `cmd_hasAny` = 0, `cmd_consume` = 0.
- Loopback: ROUTE 0x2088, XFER 0x4003, send 0x1111…, 0x2222…, 0x3333… → received in the same order. A fourth send sees `in_canReceive` = 0.
- Store and readback:
  - Store: MEMPTR 0x6005 (write pointer = 5), ROUTE 0x2028, XFER 0x4002, send 0xDEADBEEF00000001 and 0xDEADBEEF00000002.
  - Readback: MEMPTR 0x6205 (read pointer = 5), ROUTE 0x2082, XFER 0x4002.
  - Required: the same two words come out in order.
- Backpressure on loopback with `out_canReceive` held 0 → `out` is constant, `in_canReceive` = 0 after the first word, and there is no loss when released.
- ROUTE 0x2044 (keccak) then XFER 0x4004 → both are consumed, `in_canReceive` and `out_isReady` stay 0, and the next NOP is consumed immediately.
- `rst` during a 3-word loopback after 1 word → all outputs return to reset values. A subsequent XFER with no ROUTE completes without data.
